// File: rtl/trap_ctrl_pkg.sv
// ============================================================================
// Module  : trap_ctrl_pkg
// Purpose : Shared definitions for the trap controller slice.
//           Contains FSM state encodings, interrupt and exception cause codes,
//           mstatus and mie bit positions, and machine CSR addresses.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package trap_ctrl_pkg;

   // FSM state encodings
   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_FLUSH = 2'd1;
   localparam logic [1:0] c_ST_REDIR = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = c_ST_IDLE,
      ST_FLUSH = c_ST_FLUSH,
      ST_REDIR = c_ST_REDIR
   } trap_state_t;

   // Interrupt / exception cause codes
   localparam logic [3:0] c_CAUSE_MEI     = 4'd11;
   localparam logic [3:0] c_CAUSE_MSI     = 4'd3;
   localparam logic [3:0] c_CAUSE_MTI     = 4'd7;
   localparam logic [3:0] c_CAUSE_ECALL_M = 4'd11;

   // mstatus bit positions
   localparam int c_MSTATUS_MIE    = 3;
   localparam int c_MSTATUS_MPIE   = 7;
   localparam int c_MSTATUS_MPP_LO = 11;
   localparam int c_MSTATUS_MPP_HI = 12;

   // mie enable bit positions
   localparam int c_MIE_MSIE = 3;
   localparam int c_MIE_MTIE = 7;
   localparam int c_MIE_MEIE = 11;

   // Previous-privilege value for machine mode, and mtvec vectored mode
   localparam logic [1:0] c_PRV_M          = 2'b11;
   localparam logic [1:0] c_MTVEC_VECTORED = 2'b01;

   // Machine CSR addresses
   localparam logic [11:0] c_CSR_MSTATUS = 12'h300;
   localparam logic [11:0] c_CSR_MIE     = 12'h304;
   localparam logic [11:0] c_CSR_MTVEC   = 12'h305;
   localparam logic [11:0] c_CSR_MEPC    = 12'h341;
   localparam logic [11:0] c_CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] c_CSR_MTVAL   = 12'h343;
   localparam logic [11:0] c_CSR_MIP     = 12'h344;

endpackage

`default_nettype wire

// File: rtl/trap_ctrl_if.sv
// ============================================================================
// Module  : trap_ctrl_if
// Purpose : Bundle of commit, CSR, flush and redirect signals for trap_ctrl.
//           slave  modport : the trap controller
//           master modport : commit stage / CSR file / fetch environment
// Ports   : commit handshake (cmt_*), interrupt lines, CSR read values,
//           CSR write strobes/data, pipeline flush, redirect handshake.
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface trap_ctrl_if #(
   parameter int XLEN    = 64,
   parameter int CAUSE_W = 4
);
   logic               cmt_vaild;
   logic               cmt_ready;
   logic               cmt_exc;
   logic [CAUSE_W-1:0] cmt_cause;
   logic               cmt_mret;
   logic [XLEN-1:0]    cmt_pc;
   logic [XLEN-1:0]    cmt_tval;
   logic               cmt_abort;
   logic [2:0]         irq_pend;
   logic [XLEN-1:0]    mstatus_qout;
   logic [XLEN-1:0]    mie_qout;
   logic [XLEN-1:0]    mtvec_qout;
   logic [XLEN-1:0]    mepc_qout;
   logic               trap_we;
   logic [XLEN-1:0]    trap_mepc;
   logic [XLEN-1:0]    trap_mcause;
   logic [XLEN-1:0]    trap_mtval;
   logic               mstatus_we;
   logic [XLEN-1:0]    mstatus_dnxt;
   logic               beFlush;
   logic               redir_vaild;
   logic               redir_ready;
   logic [XLEN-1:0]    redir_pc;

   modport slave (
      input  cmt_vaild, cmt_exc, cmt_cause, cmt_mret, cmt_pc, cmt_tval,
      input  irq_pend, mstatus_qout, mie_qout, mtvec_qout, mepc_qout,
      input  redir_ready,
      output cmt_ready, cmt_abort,
      output trap_we, trap_mepc, trap_mcause, trap_mtval,
      output mstatus_we, mstatus_dnxt,
      output beFlush, redir_vaild, redir_pc
   );

   modport master (
      output cmt_vaild, cmt_exc, cmt_cause, cmt_mret, cmt_pc, cmt_tval,
      output irq_pend, mstatus_qout, mie_qout, mtvec_qout, mepc_qout,
      output redir_ready,
      input  cmt_ready, cmt_abort,
      input  trap_we, trap_mepc, trap_mcause, trap_mtval,
      input  mstatus_we, mstatus_dnxt,
      input  beFlush, redir_vaild, redir_pc
   );

endinterface

`default_nettype wire

// File: rtl/trap_ctrl_int_arbiter.sv
// ============================================================================
// Module  : int_arbiter
// Purpose : Masks raw machine interrupt lines with their enables and the
//           global enable, then picks one with fixed priority MEI > MSI > MTI.
// Ports   : i_irq_pend [2:0] {MEIP,MSIP,MTIP} raw pending lines
//           i_irq_en   [2:0] {MEIE,MSIE,MTIE} per-line enables
//           i_glb_en         mstatus.MIE
//           o_take           an interrupt is to be taken
//           o_code     [3:0] cause code of the winning interrupt
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module int_arbiter
   import trap_ctrl_pkg::*;
(
   input  logic [2:0] i_irq_pend,
   input  logic [2:0] i_irq_en,
   input  logic       i_glb_en,
   output logic       o_take,
   output logic [3:0] o_code
);

   logic [2:0] w_active;

   always_comb begin
      w_active = i_irq_pend & i_irq_en;
      o_take   = i_glb_en & (|w_active);
      o_code   = 4'd0;
      if (w_active[2]) begin
         o_code = c_CAUSE_MEI;
      end else if (w_active[1]) begin
         o_code = c_CAUSE_MSI;
      end else if (w_active[0]) begin
         o_code = c_CAUSE_MTI;
      end
   end

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
// Module  : trap_ctrl
// Purpose : Commit-side trap controller. Accepts a committed instruction,
//           decides between interrupt, exception and MRET, produces the
//           mepc/mcause/mtval/mstatus writes, flushes the pipeline for one
//           cycle and then hands a redirect PC to fetch over valid/ready.
// Ports   : CLK, RST (synchronous, active-high)
//           bus : trap_ctrl_if.slave (commit, CSR, flush, redirect signals)
// Config  : TRAP_VECTORED_INT_EN - when defined and mtvec[1:0]==2'b01,
//           interrupts vector to base + 4*code; exceptions always use base.
//           When undefined, mtvec[1:0] is ignored.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int CAUSE_W = 4
) (
   input  logic          CLK,
   input  logic          RST,
   trap_ctrl_if.slave    bus
);

   trap_state_t       r_state;
   logic              r_cmt_ready;
   logic              r_be_flush;
   logic              r_trap_we;
   logic              r_mstatus_we;
   logic              r_redir_vld;
   logic [XLEN-1:0]   r_mepc;
   logic [XLEN-1:0]   r_mcause;
   logic [XLEN-1:0]   r_mtval;
   logic [XLEN-1:0]   r_mstatus_nxt;
   logic [XLEN-1:0]   r_target;

   logic              w_irq_take;
   logic [3:0]        w_irq_code;
   logic              w_accept;
   logic              w_take_irq;
   logic              w_take_trap;
   logic              w_take_mret;
   logic [XLEN-1:0]   w_base;
   logic [XLEN-1:0]   w_irq_target;
   logic [XLEN-1:0]   w_trap_mcause;
   logic [XLEN-1:0]   w_trap_mtval;
   logic [XLEN-1:0]   w_trap_target;
   logic [XLEN-1:0]   w_mstatus_trap;
   logic [XLEN-1:0]   w_mstatus_mret;
   logic              w_unused_ok;

   int_arbiter u_int_arbiter (
      .i_irq_pend (bus.irq_pend),
      .i_irq_en   ({bus.mie_qout[c_MIE_MEIE],
                    bus.mie_qout[c_MIE_MSIE],
                    bus.mie_qout[c_MIE_MTIE]}),
      .i_glb_en   (bus.mstatus_qout[c_MSTATUS_MIE]),
      .o_take     (w_irq_take),
      .o_code     (w_irq_code)
   );

   // Commit events are only looked at while idle; priority irq > exc > mret.
   assign w_accept    = (r_state == ST_IDLE) & bus.cmt_vaild;
   assign w_take_irq  = w_accept & w_irq_take;
   assign w_take_trap = w_accept & (w_irq_take | bus.cmt_exc);
   assign w_take_mret = w_accept & ~w_irq_take & ~bus.cmt_exc & bus.cmt_mret;

   assign w_base = {bus.mtvec_qout[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_INT_EN
   assign w_irq_target = (bus.mtvec_qout[1:0] == c_MTVEC_VECTORED)
                       ? w_base + {{(XLEN-6){1'b0}}, w_irq_code, 2'b00}
                       : w_base;
`else
   assign w_irq_target = w_base;
`endif

   assign w_trap_mcause = w_irq_take ? {1'b1, {(XLEN-5){1'b0}}, w_irq_code}
                                     : {{(XLEN-CAUSE_W){1'b0}}, bus.cmt_cause};
   assign w_trap_mtval  = w_irq_take ? '0 : bus.cmt_tval;
   assign w_trap_target = w_irq_take ? w_irq_target : w_base;

   always_comb begin
      w_mstatus_trap = bus.mstatus_qout;
      w_mstatus_trap[c_MSTATUS_MPIE] = bus.mstatus_qout[c_MSTATUS_MIE];
      w_mstatus_trap[c_MSTATUS_MIE]  = 1'b0;
      w_mstatus_trap[c_MSTATUS_MPP_HI:c_MSTATUS_MPP_LO] = c_PRV_M;

      w_mstatus_mret = bus.mstatus_qout;
      w_mstatus_mret[c_MSTATUS_MIE]  = bus.mstatus_qout[c_MSTATUS_MPIE];
      w_mstatus_mret[c_MSTATUS_MPIE] = 1'b1;
      w_mstatus_mret[c_MSTATUS_MPP_HI:c_MSTATUS_MPP_LO] = c_PRV_M;
   end

   // Only a few mie bits and (without vectoring) no mtvec mode bits matter.
   assign w_unused_ok = &{1'b0, bus.mie_qout, bus.mtvec_qout[1:0]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state       <= ST_IDLE;
         r_cmt_ready   <= 1'b1;
         r_be_flush    <= 1'b0;
         r_trap_we     <= 1'b0;
         r_mstatus_we  <= 1'b0;
         r_redir_vld   <= 1'b0;
         r_mepc        <= '0;
         r_mcause      <= '0;
         r_mtval       <= '0;
         r_mstatus_nxt <= '0;
         r_target      <= '0;
      end else begin
         // Flush and CSR strobes live for the single FLUSH cycle only.
         r_be_flush   <= 1'b0;
         r_trap_we    <= 1'b0;
         r_mstatus_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_take_trap) begin
                  r_mepc        <= bus.cmt_pc;
                  r_mcause      <= w_trap_mcause;
                  r_mtval       <= w_trap_mtval;
                  r_mstatus_nxt <= w_mstatus_trap;
                  r_target      <= w_trap_target;
                  r_be_flush    <= 1'b1;
                  r_trap_we     <= 1'b1;
                  r_mstatus_we  <= 1'b1;
                  r_cmt_ready   <= 1'b0;
                  r_state       <= ST_FLUSH;
               end else if (w_take_mret) begin
                  r_mstatus_nxt <= w_mstatus_mret;
                  r_target      <= bus.mepc_qout;
                  r_be_flush    <= 1'b1;
                  r_mstatus_we  <= 1'b1;
                  r_cmt_ready   <= 1'b0;
                  r_state       <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               r_redir_vld <= 1'b1;
               r_state     <= ST_REDIR;
            end
            ST_REDIR: begin
               if (bus.redir_ready) begin
                  r_redir_vld <= 1'b0;
                  r_cmt_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_redir_vld <= 1'b0;
               r_cmt_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   // Abort must be visible in the accept cycle so commit does not retire.
   assign bus.cmt_abort    = w_take_irq;
   assign bus.cmt_ready    = r_cmt_ready;
   assign bus.beFlush      = r_be_flush;
   assign bus.trap_we      = r_trap_we;
   assign bus.mstatus_we   = r_mstatus_we;
   assign bus.trap_mepc    = r_mepc;
   assign bus.trap_mcause  = r_mcause;
   assign bus.trap_mtval   = r_mtval;
   assign bus.mstatus_dnxt = r_mstatus_nxt;
   assign bus.redir_vaild  = r_redir_vld;
   assign bus.redir_pc     = r_target;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// Module  : tb_trap_ctrl
// Purpose : Self-checking bench for trap_ctrl. A driver issues commit events
//           (directed cases then random ones), a reference model predicts the
//           flush-cycle CSR writes and redirect target, and a monitor pops
//           and compares them whenever the DUT flushes or hands off a redirect.
// Config  : honours TRAP_VECTORED_INT_EN the same way as the design.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_ctrl;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   trap_ctrl_if #(.XLEN(64), .CAUSE_W(4)) bus ();

   trap_ctrl #(.XLEN(64), .CAUSE_W(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        ev;
      logic        abort;
      logic        trap;
      logic [63:0] mepc;
      logic [63:0] mcause;
      logic [63:0] mtval;
      logic [63:0] mstatus;
      logic [63:0] target;
   } exp_t;

   exp_t flush_q[$];
   exp_t redir_q[$];
   int   ready_hold = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Reference model: straight from the trap rules.
   function automatic exp_t model(input bit exc, input logic [3:0] cause, input bit mret,
                                  input logic [63:0] pc, input logic [63:0] tval,
                                  input logic [2:0] irq, input logic [63:0] ms,
                                  input logic [63:0] mie, input logic [63:0] mtvec,
                                  input logic [63:0] mepc);
      exp_t e;
      int code;
      logic [63:0] base;
      e    = '0;
      code = -1;
      base = mtvec & ~64'h3;
      if (ms[3]) begin
         if (irq[2] && mie[11])      code = 11;
         else if (irq[1] && mie[3])  code = 3;
         else if (irq[0] && mie[7])  code = 7;
      end
      if (code >= 0 || exc) begin
         e.ev      = 1'b1;
         e.trap    = 1'b1;
         e.mepc    = pc;
         e.mstatus = ms;
         e.mstatus[7]     = ms[3];
         e.mstatus[3]     = 1'b0;
         e.mstatus[12:11] = 2'b11;
         e.target  = base;
         if (code >= 0) begin
            e.abort  = 1'b1;
            e.mcause = (64'h1 << 63) | 64'(code);
            e.mtval  = 64'h0;
`ifdef TRAP_VECTORED_INT_EN
            if (mtvec[1:0] == 2'b01) e.target = base + 64'(4 * code);
`endif
         end else begin
            e.mcause = 64'(cause);
            e.mtval  = tval;
         end
      end else if (mret) begin
         e.ev      = 1'b1;
         e.mstatus = ms;
         e.mstatus[3]     = ms[7];
         e.mstatus[7]     = 1'b1;
         e.mstatus[12:11] = 2'b11;
         e.target  = mepc;
      end
      return e;
   endfunction

   task automatic drive_garbage();
      bus.cmt_vaild    = 1'($urandom_range(0, 1));
      bus.cmt_exc      = 1'($urandom_range(0, 1));
      bus.cmt_cause    = 4'($urandom);
      bus.cmt_mret     = 1'($urandom_range(0, 1));
      bus.cmt_pc       = {$urandom, $urandom};
      bus.cmt_tval     = {$urandom, $urandom};
      bus.irq_pend     = 3'($urandom);
      bus.mstatus_qout = {$urandom, $urandom};
      bus.mie_qout     = {$urandom, $urandom};
      bus.mtvec_qout   = {$urandom, $urandom};
      bus.mepc_qout    = {$urandom, $urandom};
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.cmt_ready !== 1'b1) begin
         drive_garbage();
         @(posedge CLK);
         #1;
         n++;
         if (n > 200) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout actual=cmt_ready_0 required=cmt_ready_1");
            return;
         end
      end
   endtask

   task automatic issue(input bit exc, input logic [3:0] cause, input bit mret,
                        input logic [63:0] pc, input logic [63:0] tval,
                        input logic [2:0] irq, input logic [63:0] ms,
                        input logic [63:0] mie, input logic [63:0] mtvec,
                        input logic [63:0] mepc, input bit rst_in_flush);
      exp_t e;
      wait_idle();
      bus.cmt_vaild    = 1'b1;
      bus.cmt_exc      = exc;
      bus.cmt_cause    = cause;
      bus.cmt_mret     = mret;
      bus.cmt_pc       = pc;
      bus.cmt_tval     = tval;
      bus.irq_pend     = irq;
      bus.mstatus_qout = ms;
      bus.mie_qout     = mie;
      bus.mtvec_qout   = mtvec;
      bus.mepc_qout    = mepc;
      e = model(exc, cause, mret, pc, tval, irq, ms, mie, mtvec, mepc);
      #1;
      chk("cmt_abort_accept", bus.cmt_abort, e.abort);
      if (e.ev) begin
         flush_q.push_back(e);
         if (!rst_in_flush) redir_q.push_back(e);
      end
      @(posedge CLK);
      #1;
      if (e.ev) drive_garbage();
      else      bus.cmt_vaild = 1'b0;
      chk("flush_at_n1", bus.beFlush, e.ev);
      chk("cmt_ready_n1", bus.cmt_ready, !e.ev);
      if (e.ev && rst_in_flush) begin
         RST = 1'b1;
         @(posedge CLK);
         #1;
         chk("rst_beflush", bus.beFlush, 0);
         chk("rst_trap_we", bus.trap_we, 0);
         chk("rst_mstatus_we", bus.mstatus_we, 0);
         chk("rst_redir_vaild", bus.redir_vaild, 0);
         chk("rst_cmt_ready", bus.cmt_ready, 1);
         chk("rst_redir_pc", bus.redir_pc, 0);
         chk("rst_trap_mepc", bus.trap_mepc, 0);
         RST = 1'b0;
      end else if (e.ev) begin
         @(posedge CLK);
         #1;
         chk("redir_vaild_n2", bus.redir_vaild, 1);
         chk("flush_off_n2", bus.beFlush, 0);
         chk("trap_we_off_n2", bus.trap_we, 0);
      end
   endtask

   // Redirect-ready driver: random, or forced low for ready_hold cycles.
   initial begin
      bus.redir_ready = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (ready_hold > 0) begin
            bus.redir_ready = 1'b0;
            ready_hold--;
         end else begin
            bus.redir_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor / scoreboard.
   bit          mon_hold  = 1'b0;
   bit          mon_idle  = 1'b0;
   logic [63:0] mon_pc    = '0;
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (bus.beFlush === 1'b1) begin
            if (flush_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_flush actual=1 required=0");
            end else begin
               e = flush_q.pop_front();
               chk("trap_we", bus.trap_we, e.trap);
               chk("mstatus_we", bus.mstatus_we, 1);
               chk("mstatus_dnxt", bus.mstatus_dnxt, e.mstatus);
               if (e.trap) begin
                  chk("trap_mepc", bus.trap_mepc, e.mepc);
                  chk("trap_mcause", bus.trap_mcause, e.mcause);
                  chk("trap_mtval", bus.trap_mtval, e.mtval);
               end
            end
         end
         if (mon_idle) begin
            chk("idle_after_hs_ready", bus.cmt_ready, 1);
            chk("idle_after_hs_valid", bus.redir_vaild, 0);
            mon_idle = 1'b0;
         end
         if (mon_hold) begin
            chk("redir_held", bus.redir_vaild, 1);
            chk("redir_pc_stable", bus.redir_pc, mon_pc);
         end
         if (bus.redir_vaild === 1'b1) begin
            chk("cmt_ready_in_redir", bus.cmt_ready, 0);
            chk("cmt_abort_in_redir", bus.cmt_abort, 0);
            if (bus.redir_ready === 1'b1) begin
               if (redir_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_redirect actual=1 required=0");
               end else begin
                  e = redir_q.pop_front();
                  chk("redir_pc", bus.redir_pc, e.target);
               end
               mon_idle = 1'b1;
            end
         end
         mon_hold = (bus.redir_vaild === 1'b1) && (bus.redir_ready !== 1'b1);
         mon_pc   = bus.redir_pc;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmt_vaild    = 1'b0;
      bus.cmt_exc      = 1'b0;
      bus.cmt_cause    = '0;
      bus.cmt_mret     = 1'b0;
      bus.cmt_pc       = '0;
      bus.cmt_tval     = '0;
      bus.irq_pend     = '0;
      bus.mstatus_qout = '0;
      bus.mie_qout     = '0;
      bus.mtvec_qout   = '0;
      bus.mepc_qout    = '0;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_cmt_ready", bus.cmt_ready, 1);
      chk("reset_beflush", bus.beFlush, 0);
      chk("reset_trap_we", bus.trap_we, 0);
      chk("reset_mstatus_we", bus.mstatus_we, 0);
      chk("reset_redir_vaild", bus.redir_vaild, 0);
      chk("reset_redir_pc", bus.redir_pc, 0);
      chk("reset_trap_mcause", bus.trap_mcause, 0);
      chk("reset_mstatus_dnxt", bus.mstatus_dnxt, 0);
      RST = 1'b0;

      // ECALL from M-mode
      issue(1, 4'd11, 0, 64'h8000_0100, 64'h0, 3'b000, 64'h8, 64'h0,
            64'h8000_0000, 64'h0, 0);
      // MRET with MPIE=1, MIE=0
      issue(0, 4'd0, 1, 64'h8000_0200, 64'h0, 3'b000, 64'h80, 64'h0,
            64'h8000_0000, 64'h8000_0104, 0);
      // Timer interrupt, mtvec in vectored mode
      issue(0, 4'd0, 0, 64'h8000_0300, 64'h0, 3'b001, 64'h8, 64'h80,
            64'h8000_0001, 64'h0, 0);
      // MEIP+MTIP+exception together: external interrupt wins
      issue(1, 4'd2, 0, 64'h8000_0400, 64'hDEAD, 3'b101, 64'h8, 64'h880,
            64'h8000_0000, 64'h0, 0);
      // Same with global MIE clear: exception taken
      issue(1, 4'd2, 0, 64'h8000_0400, 64'hDEAD, 3'b101, 64'h0, 64'h880,
            64'h8000_0000, 64'h0, 0);
      // Plain retire: nothing happens
      issue(0, 4'd5, 0, 64'h8000_0500, 64'h0, 3'b111, 64'h0, 64'hFFFF,
            64'h8000_0000, 64'h0, 0);
      // Fetch stalls the redirect for a while
      ready_hold = 10;
      issue(1, 4'd4, 0, 64'h8000_0600, 64'h1234, 3'b000, 64'h0, 64'h0,
            64'h9000_0000, 64'h0, 0);
      // Reset lands in FLUSH
      issue(1, 4'd1, 0, 64'h8000_0700, 64'h55, 3'b000, 64'h8, 64'h0,
            64'hA000_0000, 64'h0, 1);

      for (int i = 0; i < 300; i++) begin
         logic [63:0] mtvec;
         mtvec = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) mtvec[1:0] = 2'b01;
         issue(($urandom_range(0, 3) == 0), 4'($urandom), ($urandom_range(0, 3) == 0),
               {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom}, mtvec,
               {$urandom, $urandom}, 0);
      end

      wait_idle();
      bus.cmt_vaild = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("flush_q_drained", 64'(flush_q.size()), 0);
      chk("redir_q_drained", 64'(redir_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
